// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_pkg
// Brief    : Shared helpers for the parametrised binary floating-point
//            adder: format width, bias, canonical quiet NaN, packed-field
//            extraction and the rounding-mode constant.
// Revision : 1.0 - initial release
// ============================================================================
package fp_pkg;

  // Only round-to-nearest, ties-to-even is implemented.
  typedef enum logic [1:0] {
    RM_RNE = 2'd0
  } round_mode_e;

  localparam round_mode_e ROUND_MODE = RM_RNE;

  function automatic int fp_width(input int e, input int m);
    return 1 + e + m;
  endfunction

  function automatic int fp_bias(input int e);
    return (1 << (e - 1)) - 1;
  endfunction

  // {sign 0, exponent all ones, fraction MSB 1, rest 0}
  function automatic logic [63:0] fp_qnan(input int e, input int m);
    return (((64'd1 << e) - 64'd1) << m) | (64'd1 << (m - 1));
  endfunction

  function automatic logic fp_sign_field(input logic [63:0] x, input int e, input int m);
    return 1'(x >> (e + m));
  endfunction

  function automatic logic [63:0] fp_exp_field(input logic [63:0] x, input int e, input int m);
    return (x >> m) & ((64'd1 << e) - 64'd1);
  endfunction

  function automatic logic [63:0] fp_frac_field(input logic [63:0] x, input int m);
    return x & ((64'd1 << m) - 64'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_lzc.sv
`default_nettype none
// ============================================================================
// Module   : fp_lzc
// Brief    : Combinational leading-zero counter. An all-zero input reports
//            WIDTH.
// Revision : 1.0 - initial release
// ============================================================================
module fp_lzc #(
  parameter  int WIDTH = 14,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] in_vec,
  output logic [CW-1:0]    count
);

  logic found;

  // Scan from the MSB; the first set bit fixes the count.
  always_comb begin
    count = CW'(WIDTH);
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && in_vec[i]) begin
        count = CW'(WIDTH - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_addsub_pipe
// Brief    : Pipelined IEEE-754 adder/subtractor, any EXP_W/MAN_W (FP16 by
//            default). Operands are registered on accept, then unpack/align,
//            add/lzc and normalise/round/pack stages follow, so out_valid
//            rises on the third clock edge after the accept edge. All stages
//            advance together only when the output is free or being taken.
//            Optional macro FP_ADDSUB_STICKY_FLAGS_EN adds flag_clr and
//            sticky_flags = {overflow, zero, nan, inexact}.
// Revision : 1.0 - initial release
// ============================================================================
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter  int EXP_W = 5,
  parameter  int MAN_W = 10,
  localparam int W     = fp_width(EXP_W, MAN_W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op_sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         overflow,
  output logic         zero,
  output logic         nan,
  output logic         inexact
`ifdef FP_ADDSUB_STICKY_FLAGS_EN
  ,
  input  logic         flag_clr,
  output logic [3:0]   sticky_flags
`endif
);

  localparam int FW  = MAN_W + 4;           // hidden, fraction, guard, round, sticky
  localparam int LZW = $clog2(FW + 1);
  localparam int EW1 = EXP_W + 1;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0]     QNAN = W'(fp_qnan(EXP_W, MAN_W));

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------- operand staging ----------------
  logic         r0_valid, r0_sub;
  logic [W-1:0] r0_a, r0_b;

  // Capture the operand pair; a non-accepted cycle loads a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0_valid <= 1'b0; r0_sub <= 1'b0; r0_a <= '0; r0_b <= '0;
    end else if (adv) begin
      r0_valid <= in_valid; r0_sub <= op_sub; r0_a <= a; r0_b <= b;
    end
  end

  // ---------------- S1: unpack / align ----------------
  logic             sa, sb, a_ge, s_big, nan_a, nan_b, inf_a, inf_b;
  logic [EXP_W-1:0] ea, eb, ea_adj, eb_adj, e_big, e_small, diff;
  logic [MAN_W-1:0] fa, fb;
  logic [MAN_W:0]   ma, mb, m_big, m_small;
  logic [31:0]      sh;
  logic [2*FW-1:0]  sh_wide;
  logic [FW-1:0]    m_small_al;

  // Order by magnitude, align the smaller operand and classify specials.
  always_comb begin
    sa     = fp_sign_field(64'(r0_a), EXP_W, MAN_W);
    sb     = fp_sign_field(64'(r0_b), EXP_W, MAN_W) ^ r0_sub;
    ea     = EXP_W'(fp_exp_field(64'(r0_a), EXP_W, MAN_W));
    eb     = EXP_W'(fp_exp_field(64'(r0_b), EXP_W, MAN_W));
    fa     = MAN_W'(fp_frac_field(64'(r0_a), MAN_W));
    fb     = MAN_W'(fp_frac_field(64'(r0_b), MAN_W));
    ma     = {ea != '0, fa};
    mb     = {eb != '0, fb};
    ea_adj = (ea == '0) ? EXP_W'(1) : ea;
    eb_adj = (eb == '0) ? EXP_W'(1) : eb;
    // Exponent:fraction bits order exactly like magnitudes, subnormals included.
    a_ge    = r0_a[W-2:0] >= r0_b[W-2:0];
    s_big   = a_ge ? sa : sb;
    e_big   = a_ge ? ea_adj : eb_adj;
    e_small = a_ge ? eb_adj : ea_adj;
    m_big   = a_ge ? ma : mb;
    m_small = a_ge ? mb : ma;
    diff    = e_big - e_small;
    sh      = (32'(diff) >= 32'(FW - 1)) ? 32'(FW - 1) : 32'(diff);
    // The lower half catches every bit shifted out, for the sticky bit.
    sh_wide    = {m_small, 3'b000, {FW{1'b0}}} >> sh;
    m_small_al = {sh_wide[2*FW-1:FW+1], sh_wide[FW] | (|sh_wide[FW-1:0])};
    nan_a = (ea == EMAX) && (fa != '0);
    nan_b = (eb == EMAX) && (fb != '0);
    inf_a = (ea == EMAX) && (fa == '0);
    inf_b = (eb == EMAX) && (fb == '0);
  end

  logic             r1_valid, r1_sign, r1_zsign, r1_sub, r1_nan, r1_inf, r1_inf_sign;
  logic [EXP_W-1:0] r1_exp;
  logic [FW-1:0]    r1_mb, r1_ms;

  // Register the aligned operands and special-case classification.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_valid <= 1'b0; r1_sign <= 1'b0; r1_zsign <= 1'b0; r1_sub <= 1'b0;
      r1_nan <= 1'b0; r1_inf <= 1'b0; r1_inf_sign <= 1'b0;
      r1_exp <= '0; r1_mb <= '0; r1_ms <= '0;
    end else if (adv) begin
      r1_valid    <= r0_valid;
      r1_sign     <= s_big;
      r1_zsign    <= sa & sb;              // exact zero is -0 only for (-0)+(-0)
      r1_sub      <= sa ^ sb;
      r1_nan      <= nan_a | nan_b | (inf_a & inf_b & (sa ^ sb));
      r1_inf      <= inf_a | inf_b;
      r1_inf_sign <= inf_a ? sa : sb;
      r1_exp      <= e_big;
      r1_mb       <= {m_big, 3'b000};
      r1_ms       <= m_small_al;
    end
  end

  // ---------------- S2: add / lzc ----------------
  logic [FW:0]    sum2;
  logic [LZW-1:0] lzc2;

  assign sum2 = r1_sub ? ({1'b0, r1_mb} - {1'b0, r1_ms}) : ({1'b0, r1_mb} + {1'b0, r1_ms});

  fp_lzc #(.WIDTH(FW)) u_lzc (
    .in_vec (sum2[FW-1:0]),
    .count  (lzc2)
  );

  logic             r2_valid, r2_sign, r2_zsign, r2_nan, r2_inf, r2_inf_sign;
  logic [EXP_W-1:0] r2_exp;
  logic [FW:0]      r2_sum;
  logic [LZW-1:0]   r2_lzc;

  // Register the raw magnitude sum and its leading-zero count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r2_valid <= 1'b0; r2_sign <= 1'b0; r2_zsign <= 1'b0; r2_nan <= 1'b0;
      r2_inf <= 1'b0; r2_inf_sign <= 1'b0; r2_exp <= '0; r2_sum <= '0; r2_lzc <= '0;
    end else if (adv) begin
      r2_valid <= r1_valid; r2_sign <= r1_sign; r2_zsign <= r1_zsign; r2_nan <= r1_nan;
      r2_inf <= r1_inf; r2_inf_sign <= r1_inf_sign; r2_exp <= r1_exp;
      r2_sum <= sum2; r2_lzc <= lzc2;
    end
  end

  // ---------------- S3: normalise / round / pack ----------------
  logic [31:0]      lim, lsh;
  logic [FW-1:0]    norm;
  logic [EW1-1:0]   e_pre, e_fin;
  logic [MAN_W+1:0] mant_r;
  logic [MAN_W-1:0] frac;
  logic             rup, inx, res_sign;
  logic [W-1:0]     n_result;
  logic             n_ovf, n_zero, n_nan, n_inx;

  // Normalise (left shift stops at exponent 1, giving subnormals), round RNE, pack.
  always_comb begin
    lim = 32'(r2_exp) - 32'd1;
    lsh = (32'(r2_lzc) < lim) ? 32'(r2_lzc) : lim;
    if (r2_sum[FW]) begin
      norm  = {r2_sum[FW:2], r2_sum[1] | r2_sum[0]};
      e_pre = {1'b0, r2_exp} + EW1'(1);
    end else begin
      norm  = r2_sum[FW-1:0] << lsh;
      e_pre = {1'b0, r2_exp} - EW1'(lsh);
    end
    rup    = (ROUND_MODE == RM_RNE) && norm[2] && (norm[1] || norm[0] || norm[3]);
    inx    = norm[2] | norm[1] | norm[0];
    mant_r = {1'b0, norm[FW-1:3]} + (MAN_W+2)'(rup);
    if (mant_r[MAN_W+1]) begin
      e_fin = e_pre + EW1'(1);
      frac  = mant_r[MAN_W:1];
    end else begin
      e_fin = mant_r[MAN_W] ? e_pre : '0;
      frac  = mant_r[MAN_W-1:0];
    end
    res_sign = (r2_sum == '0) ? r2_zsign : r2_sign;

    n_ovf = 1'b0; n_nan = 1'b0; n_inx = 1'b0;
    if (r2_nan) begin
      n_result = QNAN;
      n_nan    = 1'b1;
    end else if (r2_inf) begin
      n_result = {r2_inf_sign, EMAX, {MAN_W{1'b0}}};
    end else if (e_fin >= {1'b0, EMAX}) begin
      n_result = {res_sign, EMAX, {MAN_W{1'b0}}};
      n_ovf    = 1'b1;
      n_inx    = 1'b1;
    end else begin
      n_result = {res_sign, e_fin[EXP_W-1:0], frac};
      n_inx    = inx;
    end
    n_zero = !r2_nan && (n_result[W-2:0] == '0);
  end

  // Output register: result and flags move together and hold under stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0; result <= '0;
      overflow <= 1'b0; zero <= 1'b0; nan <= 1'b0; inexact <= 1'b0;
    end else if (adv) begin
      out_valid <= r2_valid; result <= n_result;
      overflow <= n_ovf; zero <= n_zero; nan <= n_nan; inexact <= n_inx;
    end
  end

`ifdef FP_ADDSUB_STICKY_FLAGS_EN
  logic hs;
  assign hs = out_valid && out_ready;

  // OR in each handed-off result's flags; a clear keeps only this cycle's flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_flags <= 4'b0000;
    end else if (flag_clr) begin
      sticky_flags <= hs ? {overflow, zero, nan, inexact} : 4'b0000;
    end else if (hs) begin
      sticky_flags <= sticky_flags | {overflow, zero, nan, inexact};
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_addsub_pipe
// Brief    : Self-checking bench for fp_addsub_pipe (FP16). Directed vector
//            table plus backpressure, reset and (with FP_ADDSUB_STICKY_FLAGS_EN)
//            sticky-flag sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_addsub_pipe;

  logic        clk, rst, in_valid, in_ready, op_sub, out_valid, out_ready;
  logic [15:0] a, b, result;
  logic        overflow, zero, nan, inexact;
`ifdef FP_ADDSUB_STICKY_FLAGS_EN
  logic        flag_clr;
  logic [3:0]  sticky_flags;
`endif

  int passed = 0;
  int total  = 0;

  fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .zero      (zero),
    .nan       (nan),
    .inexact   (inexact)
`ifdef FP_ADDSUB_STICKY_FLAGS_EN
    ,
    .flag_clr     (flag_clr),
    .sticky_flags (sticky_flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] res;
    logic [3:0]  flg;    // {overflow, zero, nan, inexact}
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
  endtask

  // One operation on an otherwise idle pipe; lat counts edges after accept.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic ts,
                       output logic [15:0] r, output logic [3:0] f, output int lat);
    @(negedge clk);
    a = ta; b = tb; op_sub = ts; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) break;
    end
    r = result;
    f = {overflow, zero, nan, inexact};
  endtask

  initial begin
    logic [15:0] r;
    logic [3:0]  f;
    int          lat, sent, got, cyc, seen;
    logic        acc, hs, stall_seen;

    vecs[0]  = '{16'h3c00, 16'h3c00, 1'b0, 16'h4000, 4'b0000};
    vecs[1]  = '{16'h3c00, 16'h3c00, 1'b1, 16'h0000, 4'b0100};
    vecs[2]  = '{16'h5640, 16'hd640, 1'b0, 16'h0000, 4'b0100};
    vecs[3]  = '{16'h7bff, 16'h7bff, 1'b0, 16'h7c00, 4'b1001};
    vecs[4]  = '{16'h7c00, 16'h4000, 1'b0, 16'h7c00, 4'b0000};
    vecs[5]  = '{16'h7c00, 16'hfc00, 1'b0, 16'h7e00, 4'b0010};
    vecs[6]  = '{16'h7cff, 16'h3c00, 1'b0, 16'h7e00, 4'b0010};
    vecs[7]  = '{16'h00b8, 16'h0080, 1'b0, 16'h0138, 4'b0000};
    vecs[8]  = '{16'h3c00, 16'h0001, 1'b0, 16'h3c00, 4'b0001};
    vecs[9]  = '{16'h3c00, 16'h1000, 1'b0, 16'h3c00, 4'b0001};  // tie, even stays
    vecs[10] = '{16'h3c01, 16'h1000, 1'b0, 16'h3c02, 4'b0001};  // tie, odd rounds up
    vecs[11] = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 4'b0100};  // -0 + -0
    vecs[12] = '{16'h4000, 16'h3c00, 1'b1, 16'h3c00, 4'b0000};  // 2 - 1
    vecs[13] = '{16'h3c00, 16'h4000, 1'b1, 16'hbc00, 4'b0000};  // 1 - 2
    vecs[14] = '{16'h0400, 16'h0001, 1'b1, 16'h03ff, 4'b0000};  // normal -> subnormal
    vecs[15] = '{16'h3c00, 16'h0000, 1'b0, 16'h3c00, 4'b0000};
    vecs[16] = '{16'h3e00, 16'h3e00, 1'b0, 16'h4200, 4'b0000};  // 1.5 + 1.5
    vecs[17] = '{16'h3bff, 16'h0c00, 1'b0, 16'h3c00, 4'b0001};  // round carries exponent

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op_sub = 1'b0; a = '0; b = '0;
`ifdef FP_ADDSUB_STICKY_FLAGS_EN
    flag_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_result", {16'b0, result}, 0);
    chk("rst_flags", {28'b0, overflow, zero, nan, inexact}, 0);
`ifdef FP_ADDSUB_STICKY_FLAGS_EN
    chk("rst_sticky", {28'b0, sticky_flags}, 0);
`endif
    rst = 1'b0;
    #1 chk("rst_in_ready", {31'b0, in_ready}, 1);

    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].sub, r, f, lat);
      chk($sformatf("v%0d_lat", i), 32'(lat), 3);
      chk($sformatf("v%0d_res", i), {16'b0, r}, {16'b0, vecs[i].res});
      chk($sformatf("v%0d_flags", i), {28'b0, f}, {28'b0, vecs[i].flg});
    end

    // Backpressure: six accepts attempted back-to-back, consumer stalled 5 cycles.
    idle(3);
    sent = 0; got = 0; cyc = 0; stall_seen = 1'b0;
    while (got < 6 && cyc < 60) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      in_valid  = (sent < 6);
      a = 16'h3c00 + 16'(sent); b = 16'h0000; op_sub = 1'b0;
      #1;
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      if (out_valid && !out_ready && !stall_seen) begin
        stall_seen = 1'b1;
        chk("bp_in_ready_low", {31'b0, in_ready}, 0);
      end
      if (hs) begin
        chk($sformatf("bp_res%0d", got), {16'b0, result}, {16'b0, 16'h3c00 + 16'(got)});
        got++;
      end
      if (acc) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("bp_stall_seen", {31'b0, stall_seen}, 1);
    chk("bp_count", 32'(got), 6);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      #1 if (out_valid) seen++;
    end
    chk("bp_no_dup", 32'(seen), 0);

`ifdef FP_ADDSUB_STICKY_FLAGS_EN
    idle(2);
    @(negedge clk); flag_clr = 1'b1;
    @(negedge clk); flag_clr = 1'b0;
    #1 chk("sticky_clr0", {28'b0, sticky_flags}, 0);
    do_op(16'h7bff, 16'h7bff, 1'b0, r, f, lat);
    do_op(16'h3c00, 16'h0001, 1'b0, r, f, lat);
    idle(2);
    #1 chk("sticky_acc", {28'b0, sticky_flags}, {28'b0, 4'b1001});
    @(negedge clk); flag_clr = 1'b1;
    @(negedge clk); flag_clr = 1'b0;
    #1 chk("sticky_clr1", {28'b0, sticky_flags}, 0);
`endif

    // Reset mid-stream: fill with the consumer stalled, then reset.
    idle(2);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; a = 16'h4000; b = 16'h3c00; op_sub = 1'b0;
      #1 cyc++;
    end
    chk("mid_filled", {31'b0, out_valid}, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'b0, out_valid}, 0);
    chk("mid_rst_result", {16'b0, result}, 0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      #1 if (out_valid) seen++;
    end
    chk("mid_rst_no_output", 32'(seen), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
